m24lc64_slave: RTL and testbench

- Synthesizable, clock-oversampled model of a 64-Kbit (8192 x 8) I2C serial EEPROM, compatible with the 24LC64 protocol.
- Sits on the board-level I2C bus as the target of the cdc I2C master.
- The I2C config/write/read commands from the USB command path must round-trip data through this block.
- SCL and SDA are sampled on clk; SDA is driven open-drain.

---
 rtl/m24lc64_pkg.sv | 35 +++
 rtl/m24lc64_slave_sync.sv | 55 +++++
 rtl/m24lc64_slave.sv | 218 +++++++++++++++++++++
 tb/tb_m24lc64_slave.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m24lc64_pkg.sv
// m24lc64_pkg: shared types and constants for the 24LC64-compatible I2C
// EEPROM target model.
//   state_t    - protocol state of the byte-level I2C engine
//   CTRL_CODE  - fixed upper nibble of the device address byte
//   ADDR_W     - byte address width (8192 bytes)
//   PAGE_W     - page offset width (32-byte pages)
//   dev_match  - compares a received address byte with the strap pins
package m24lc64_pkg;

  localparam logic [3:0] CTRL_CODE = 4'b1010;
  localparam int         ADDR_W    = 13;
  localparam int         PAGE_W    = 5;

  typedef enum logic [3:0] {
    IDLE,
    DEVADDR,
    DEV_ACK,
    ADDRH,
    ADDRH_ACK,
    ADDRL,
    ADDRL_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_MACK,
    IGNORE
  } state_t;

  // Bit 0 of the address byte is R/W and does not take part in selection.
  function automatic logic dev_match(input logic [7:0] ctrl,
                                     input logic [2:0] straps);
    return ctrl[7:1] == {CTRL_CODE, straps};
  endfunction

endpackage

// File: rtl/m24lc64_slave_sync.sv
// i2c_bus_sync: brings the asynchronous SCL/SDA bus levels into the clk
// domain and derives single-cycle bus event pulses.
//   clk, rst   - system clock, synchronous active-high reset
//   scl_line   - raw SCL level from the bus
//   sda_line   - raw SDA level from the bus
//   sda_level  - synchronized SDA level (sample this on scl_rise)
//   scl_rise   - one-cycle pulse on a synchronized SCL rising edge
//   scl_fall   - one-cycle pulse on a synchronized SCL falling edge
//   start      - SDA fell while SCL was high
//   stop       - SDA rose while SCL was high
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_line,
  input  logic sda_line,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_prev;
  logic       sda_prev;
  logic       scl_now;
  logic       sda_now;

  // Reset to the idle bus level so leaving reset cannot fake a START.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_line};
      sda_sync <= {sda_sync[0], sda_line};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  assign scl_now   = scl_sync[1];
  assign sda_now   = sda_sync[1];
  assign sda_level = sda_now;
  assign scl_rise  = scl_now & ~scl_prev;
  assign scl_fall  = ~scl_now & scl_prev;
  // SCL must be high on both samples so an SCL edge coinciding with an SDA
  // change is never taken for a bus condition.
  assign start     = scl_now & scl_prev & sda_prev & ~sda_now;
  assign stop      = scl_now & scl_prev & ~sda_prev & sda_now;

endmodule

// File: rtl/m24lc64_slave.sv
// m24lc64_slave: clock-oversampled, synthesizable model of a 64-Kbit
// (8192 x 8) 24LC64-style I2C serial EEPROM target.
//   clk          - system clock, at least 20x the SCL rate
//   rst          - synchronous active-high reset (memory is kept)
//   a0, a1, a2   - chip-select address straps
//   wp           - write protect, high blocks memory writes
//   scl_i        - bus SCL level (no clock stretching)
//   sda_i        - bus SDA level
//   sda_oe       - 1 pulls SDA low, 0 releases it
//   busy         - high during the internal write cycle
module m24lc64_slave
  import m24lc64_pkg::*;
#(
  parameter int WRITE_CYCLES = 150000,
  parameter int MEM_DEPTH    = 8192,
  parameter int PAGE_SIZE    = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic wp,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe,
  output logic busy
);

  localparam int                 CNT_W     = $clog2(WRITE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   WC_LOAD   = CNT_W'(WRITE_CYCLES - 1);
  localparam logic [PAGE_W-1:0]  PAGE_MASK = PAGE_W'(PAGE_SIZE - 1);

  logic sda_level;
  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_line  (scl_i),
    .sda_line  (sda_i),
    .sda_level (sda_level),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start     (start),
    .stop      (stop)
  );

  state_t                    state;
  logic [3:0]                bit_cnt;
  logic [7:0]                shreg;
  logic [7:0]                tx;
  logic [7:0]                wbyte;
  logic [ADDR_W-9:0]         addrh;
  logic [ADDR_W-1:0]         ptr;
  logic                      rw;
  logic                      mack;
  logic                      wrote;
  logic                      mem_we;
  logic [CNT_W-1:0]          wc_cnt;
  logic [7:0]                rd_data;
  logic [7:0]                mem [MEM_DEPTH];

  // Single-port storage addressed by the pointer. The pointer is stable for
  // many clocks before a byte is loaded for transmit, so the registered read
  // is always current when used.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= wbyte;
    rd_data <= mem[ptr];
  end

  // Receive shifter: MSB first on every synchronized SCL rise.
  always_ff @(posedge clk) begin
    if (scl_rise) shreg <= {shreg[6:0], sda_level};
  end

  always_ff @(posedge clk) begin
    mem_we <= 1'b0;
    if (rst) begin
      state   <= IDLE;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      ptr     <= '0;
      bit_cnt <= '0;
      rw      <= 1'b0;
      mack    <= 1'b0;
      wrote   <= 1'b0;
      wc_cnt  <= '0;
    end else begin
      if (busy) begin
        if (wc_cnt == '0) busy <= 1'b0;
        else              wc_cnt <= wc_cnt - 1'b1;
      end

      if (stop) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
        // Only a transfer that actually stored data starts tWR.
        if (wrote) begin
          busy   <= 1'b1;
          wc_cnt <= WC_LOAD;
          wrote  <= 1'b0;
        end
      end else if (start) begin
        state   <= DEVADDR;
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
      end else begin
        if (scl_rise) begin
          case (state)
            DEVADDR, ADDRH, ADDRL, WDATA, RDATA: bit_cnt <= bit_cnt + 4'd1;
            RDATA_MACK:                          mack <= ~sda_level;
            default: ;
          endcase
        end

        // All SDA changes happen just after a synchronized SCL fall.
        if (scl_fall) begin
          case (state)
            DEVADDR: begin
              if (bit_cnt == 4'd8) begin
                if (dev_match(shreg, {a2, a1, a0}) && !busy) begin
                  state  <= DEV_ACK;
                  sda_oe <= 1'b1;
                  rw     <= shreg[0];
                end else begin
                  state  <= IGNORE;
                  sda_oe <= 1'b0;
                end
              end
            end
            DEV_ACK: begin
              bit_cnt <= '0;
              if (rw) begin
                tx     <= rd_data;
                sda_oe <= ~rd_data[7];
                ptr    <= ptr + 1'b1;
                state  <= RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= ADDRH;
              end
            end
            ADDRH: begin
              if (bit_cnt == 4'd8) begin
                addrh  <= shreg[ADDR_W-9:0];
                sda_oe <= 1'b1;
                state  <= ADDRH_ACK;
              end
            end
            ADDRH_ACK: begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= ADDRL;
            end
            ADDRL: begin
              if (bit_cnt == 4'd8) begin
                ptr    <= {addrh, shreg};
                sda_oe <= 1'b1;
                state  <= ADDRL_ACK;
              end
            end
            ADDRL_ACK: begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= WDATA;
            end
            WDATA: begin
              if (bit_cnt == 4'd8) begin
                // Protected bytes are still acknowledged, just not stored.
                wbyte  <= shreg;
                sda_oe <= 1'b1;
                state  <= WDATA_ACK;
                if (!wp) begin
                  mem_we <= 1'b1;
                  wrote  <= 1'b1;
                end
              end
            end
            WDATA_ACK: begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              // Wrap within the page; the page number never changes here.
              ptr[PAGE_W-1:0] <= (ptr[PAGE_W-1:0] + 1'b1) & PAGE_MASK;
              state   <= WDATA;
            end
            RDATA: begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= RDATA_MACK;
              end else begin
                sda_oe <= ~tx[3'(4'd7 - bit_cnt)];
              end
            end
            RDATA_MACK: begin
              bit_cnt <= '0;
              if (mack) begin
                tx     <= rd_data;
                sda_oe <= ~rd_data[7];
                ptr    <= ptr + 1'b1;
                state  <= RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= IGNORE;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_m24lc64_slave.sv
// tb_m24lc64_slave: bus-functional I2C master driving m24lc64_slave, with a
// byte-level memory model and an expected-read queue as scoreboard.
// SCL runs at clk/40 and tWR is shortened so the run stays short.
module tb_m24lc64_slave;

  localparam int WC = 2000;
  localparam int Q  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a0 = 1'b0, a1 = 1'b0, a2 = 1'b0;
  logic wp = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe, busy;
  logic scl_i, sda_i;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  m24lc64_slave #(.WRITE_CYCLES(WC), .MEM_DEPTH(8192), .PAGE_SIZE(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .a0     (a0),
    .a1     (a1),
    .a2     (a2),
    .wp     (wp),
    .scl_i  (scl_i),
    .sda_i  (sda_i),
    .sda_oe (sda_oe),
    .busy   (busy)
  );

  always #10 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int busy_cycles = 0;
  int oe_cycles = 0;

  always @(negedge clk) begin
    if (busy === 1'b1)   busy_cycles++;
    if (sda_oe === 1'b1) oe_cycles++;
  end

  logic [7:0] model_mem [0:8191];
  logic [7:0] wbuf [0:31];
  logic [7:0] exp_q [$];
  logic [7:0] rd_q [$];

  initial begin
    #1800000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = sda_i;    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic get_byte(output logic [7:0] d, input logic give_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~give_ack);
  endtask

  // Write n bytes from wbuf starting at addr, then STOP; the model follows
  // the page-wrap rule unless write protect is set.
  task automatic write_txn(input logic [12:0] addr, input int n, output int acks);
    logic ack;
    logic [12:0] ma;
    acks = 0;
    bus_start();
    put_byte({4'hA, a2, a1, a0, 1'b0}, ack); acks += int'(ack);
    put_byte({3'b000, addr[12:8]}, ack);     acks += int'(ack);
    put_byte(addr[7:0], ack);                acks += int'(ack);
    for (int i = 0; i < n; i++) begin
      put_byte(wbuf[i], ack); acks += int'(ack);
      ma = (addr & 13'h1FE0) | 13'((int'(addr[4:0]) + i) % 32);
      if (!wp) model_mem[ma] = wbuf[i];
    end
    bus_stop();
  endtask

  // Random read of n bytes: expected bytes queued as the read is issued,
  // received bytes queued as they arrive; the last byte is NACKed.
  task automatic read_txn(input logic [12:0] addr, input int n, output int acks);
    logic ack;
    logic [7:0] d;
    acks = 0;
    bus_start();
    put_byte({4'hA, a2, a1, a0, 1'b0}, ack); acks += int'(ack);
    put_byte({3'b000, addr[12:8]}, ack);     acks += int'(ack);
    put_byte(addr[7:0], ack);                acks += int'(ack);
    bus_start();
    put_byte({4'hA, a2, a1, a0, 1'b1}, ack); acks += int'(ack);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_mem[13'(int'(addr) + i)]);
      get_byte(d, i < n - 1);
      rd_q.push_back(d);
    end
    bus_stop();
  endtask

  task automatic wait_not_busy(output logic ok);
    for (int i = 0; i < WC + 200 && busy; i++) wait_clk(1);
    ok = ~busy;
  endtask

  task automatic test_reset();
    int acks;
    logic ok, ack;
    logic [7:0] d, e;
    rst = 1'b1; wait_clk(5); rst = 1'b0; wait_clk(2);
    n_chk++;
    if (sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    n_chk++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    wbuf[0] = 8'h5A;
    write_txn(13'h0000, 1, acks);
    n_chk++;
    if (acks != 4) begin n_err++; $display("FAIL reset_prep_acks: got %0d want 4", acks); end
    wait_not_busy(ok);
    n_chk++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL reset_prep_busy_timeout: busy still %b", busy); end
    // Reset must return the pointer to 0: a current-address read sees 0x0000.
    rst = 1'b1; wait_clk(1); rst = 1'b0; wait_clk(2);
    bus_start();
    put_byte({4'hA, a2, a1, a0, 1'b1}, ack);
    exp_q.push_back(model_mem[0]);
    get_byte(d, 1'b0);
    rd_q.push_back(d);
    bus_stop();
    n_chk++;
    if (ack !== 1'b1) begin n_err++; $display("FAIL reset_cur_read_ack: got %b want 1", ack); end
    e = exp_q.pop_front(); d = rd_q.pop_front();
    n_chk++;
    if (d !== e) begin n_err++; $display("FAIL reset_cur_read_data: got %h want %h", d, e); end
  endtask

  task automatic test_page_write();
    int acks, b0;
    logic ok;
    logic [7:0] d, e;
    wbuf[0] = 8'hDE; wbuf[1] = 8'hAD; wbuf[2] = 8'hBE; wbuf[3] = 8'hEF;
    b0 = busy_cycles;
    write_txn(13'h003C, 4, acks);
    n_chk++;
    if (acks != 7) begin n_err++; $display("FAIL page_write_acks: got %0d want 7", acks); end
    wait_not_busy(ok);
    n_chk++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL page_write_busy_timeout: busy still %b", busy); end
    n_chk++;
    if (busy_cycles - b0 != WC) begin
      n_err++; $display("FAIL page_write_busy_len: got %0d want %0d", busy_cycles - b0, WC);
    end
    read_txn(13'h003C, 4, acks);
    n_chk++;
    if (acks != 4) begin n_err++; $display("FAIL page_read_acks: got %0d want 4", acks); end
    while (exp_q.size() > 0 && rd_q.size() > 0) begin
      e = exp_q.pop_front(); d = rd_q.pop_front();
      n_chk++;
      if (d !== e) begin n_err++; $display("FAIL page_read_data: got %h want %h", d, e); end
    end
  endtask

  task automatic test_ack_polling();
    int acks;
    logic ok, ack;
    wbuf[0] = 8'h12;
    write_txn(13'h0080, 1, acks);
    bus_start();
    put_byte(8'hA0, ack);
    bus_stop();
    n_chk++;
    if (ack !== 1'b0) begin n_err++; $display("FAIL poll_busy_nack: ack %b want 0", ack); end
    n_chk++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL poll_busy_level: got %b want 1", busy); end
    wait_not_busy(ok);
    n_chk++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL poll_busy_timeout: busy still %b", busy); end
    bus_start();
    put_byte(8'hA0, ack);
    bus_stop();
    wait_clk(10);
    n_chk++;
    if (ack !== 1'b1) begin n_err++; $display("FAIL poll_ready_ack: ack %b want 1", ack); end
    n_chk++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL poll_no_write_cycle: busy %b want 0", busy); end
  endtask

  task automatic test_addr_mismatch();
    int o0;
    logic ack0, ack1, ack2;
    o0 = oe_cycles;
    bus_start();
    put_byte(8'hA2, ack0);
    put_byte(8'h00, ack1);
    bus_stop();
    n_chk++;
    if (ack0 !== 1'b0) begin n_err++; $display("FAIL mismatch_nack: ack %b want 0", ack0); end
    n_chk++;
    if (oe_cycles != o0) begin n_err++; $display("FAIL mismatch_sda_oe: %0d driven cycles want 0", oe_cycles - o0); end
    // With strap a0=1 the same address byte selects this device.
    a0 = 1'b1;
    bus_start();
    put_byte(8'hA2, ack2);
    bus_stop();
    a0 = 1'b0;
    n_chk++;
    if (ack2 !== 1'b1) begin n_err++; $display("FAIL strap_match_ack: ack %b want 1", ack2); end
  endtask

  task automatic test_page_rollover();
    int acks, racks;
    logic ok;
    logic [7:0] d, e;
    logic [12:0] addrs [4];
    wbuf[0] = 8'h99;
    write_txn(13'h0040, 1, acks);
    wait_not_busy(ok);
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    write_txn(13'h003F, 3, acks);
    n_chk++;
    if (acks != 6) begin n_err++; $display("FAIL rollover_acks: got %0d want 6", acks); end
    wait_not_busy(ok);
    n_chk++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL rollover_busy_timeout: busy still %b", busy); end
    addrs[0] = 13'h003F; addrs[1] = 13'h0020; addrs[2] = 13'h0021; addrs[3] = 13'h0040;
    for (int i = 0; i < 4; i++) begin
      read_txn(addrs[i], 1, racks);
      e = exp_q.pop_front(); d = rd_q.pop_front();
      n_chk++;
      if (d !== e) begin n_err++; $display("FAIL rollover_data[%h]: got %h want %h", addrs[i], d, e); end
    end
  endtask

  task automatic test_write_protect();
    int acks, b0;
    logic ok;
    logic [7:0] d, e;
    wbuf[0] = 8'h77;
    write_txn(13'h0100, 1, acks);
    wait_not_busy(ok);
    wp = 1'b1;
    wbuf[0] = 8'h55;
    b0 = busy_cycles;
    write_txn(13'h0100, 1, acks);
    wait_clk(20);
    wp = 1'b0;
    n_chk++;
    if (acks != 4) begin n_err++; $display("FAIL wp_acks: got %0d want 4", acks); end
    n_chk++;
    if (busy_cycles != b0) begin n_err++; $display("FAIL wp_no_busy: %0d busy cycles want 0", busy_cycles - b0); end
    read_txn(13'h0100, 1, acks);
    e = exp_q.pop_front(); d = rd_q.pop_front();
    n_chk++;
    if (d !== e) begin n_err++; $display("FAIL wp_readback: got %h want %h", d, e); end
  endtask

  task automatic test_seq_wrap();
    int acks;
    logic ok;
    logic [7:0] d, e;
    wbuf[0] = 8'hC3;
    write_txn(13'h1FFF, 1, acks);
    wait_not_busy(ok);
    read_txn(13'h1FFF, 2, acks);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front(); d = rd_q.pop_front();
      n_chk++;
      if (d !== e) begin n_err++; $display("FAIL seq_wrap_data[%0d]: got %h want %h", i, d, e); end
    end
  endtask

  task automatic test_reset_mid_read();
    int acks;
    logic ack, b;
    logic [7:0] d, e;
    // 0x003C holds 0xDE = 1101_1110, so the third bit is a driven '0'.
    bus_start();
    put_byte(8'hA0, ack);
    put_byte(8'h00, ack);
    put_byte(8'h3C, ack);
    bus_start();
    put_byte(8'hA1, ack);
    get_bit(b);
    get_bit(b);
    n_chk++;
    if (sda_oe !== 1'b1) begin n_err++; $display("FAIL midread_driving_zero: sda_oe %b want 1", sda_oe); end
    rst = 1'b1; wait_clk(1); rst = 1'b0;
    n_chk++;
    if (sda_oe !== 1'b0) begin n_err++; $display("FAIL midread_reset_release: sda_oe %b want 0", sda_oe); end
    wait_clk(5);
    read_txn(13'h003C, 1, acks);
    n_chk++;
    if (acks != 4) begin n_err++; $display("FAIL midread_after_acks: got %0d want 4", acks); end
    e = exp_q.pop_front(); d = rd_q.pop_front();
    n_chk++;
    if (d !== e) begin n_err++; $display("FAIL midread_after_data: got %h want %h", d, e); end
  endtask

  initial begin
    test_reset();
    test_page_write();
    test_ack_polling();
    test_addr_mismatch();
    test_page_rollover();
    test_write_protect();
    test_seq_wrap();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
